// File: rtl/ttt_processor_array.sv
// rtl/ttt_processor_array.sv - multi-channel token-threshold-timer array (optional TTT_REFRACTORY_EN)
module ttt_processor_array #(
    parameter int NUM_CHANNELS     = 4,
    parameter int NEW_TOKEN_BITS   = 4,
    parameter int TOKEN_BITS       = 8,
    parameter int DURATION_BITS    = 8,
    parameter int DATA_BITS        = 8,
    parameter int ADDR_BITS        = 2,
    parameter int REFRACTORY_STEPS = 2
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   enable,
    input  logic [3:0]                             instruction,
    input  logic [ADDR_BITS-1:0]                   channel_addr,
    input  logic                                   broadcast,
    input  logic [NUM_CHANNELS*NEW_TOKEN_BITS-1:0] good_tokens_in,
    input  logic [NUM_CHANNELS*NEW_TOKEN_BITS-1:0] bad_tokens_in,
    output logic [NUM_CHANNELS-1:0]                token_start,
    output logic [NUM_CHANNELS-1:0]                token_stop,
    output logic [NUM_CHANNELS-1:0]                token_valid,
    input  logic [DATA_BITS-1:0]                   data_in,
    output logic [DATA_BITS-1:0]                   data_out
);
    localparam logic [3:0] OP_ADD_GOOD = 4'b0000, OP_ADD_BAD = 4'b0001, OP_SET_GOOD = 4'b0010,
                           OP_GET_GOOD = 4'b0011, OP_SET_BAD = 4'b0100, OP_GET_BAD  = 4'b0101,
                           OP_SET_REM  = 4'b0110, OP_GET_REM = 4'b0111, OP_TALLY    = 4'b1000,
                           OP_COUNT    = 4'b1001, OP_SET_GTH = 4'b1010, OP_GET_GTH  = 4'b1011,
                           OP_SET_BTH  = 4'b1100, OP_GET_BTH = 4'b1101, OP_SET_DUR  = 4'b1110,
                           OP_GET_DUR  = 4'b1111;
    localparam logic signed [TOKEN_BITS-1:0] TOK_MAX = {1'b0, {(TOKEN_BITS-1){1'b1}}};
    localparam logic signed [TOKEN_BITS-1:0] TOK_MIN = {1'b1, {(TOKEN_BITS-1){1'b0}}};

`ifdef TTT_REFRACTORY_EN
    localparam int RB = (REFRACTORY_STEPS < 1) ? 1 : $clog2(REFRACTORY_STEPS + 1);
    typedef enum logic [1:0] {ST_OFF, ST_ON, ST_REFR} state_t;
`else
    typedef enum logic [1:0] {ST_OFF, ST_ON} state_t;
    logic unused_refr_steps;
    assign unused_refr_steps = (REFRACTORY_STEPS != 0);
`endif

    // Clamp counter + delta into the signed counter range instead of wrapping.
    function automatic logic signed [TOKEN_BITS-1:0] sat_add(input logic signed [TOKEN_BITS-1:0] a,
                                                              input logic signed [NEW_TOKEN_BITS-1:0] d);
        logic signed [TOKEN_BITS:0] s;
        s = (TOKEN_BITS+1)'(a) + (TOKEN_BITS+1)'(d);
        if (s > (TOKEN_BITS+1)'(TOK_MAX))      return TOK_MAX;
        else if (s < (TOKEN_BITS+1)'(TOK_MIN)) return TOK_MIN;
        else                                   return s[TOKEN_BITS-1:0];
    endfunction

    logic signed [TOKEN_BITS-1:0]    good_q [NUM_CHANNELS];
    logic signed [TOKEN_BITS-1:0]    bad_q  [NUM_CHANNELS];
    logic signed [TOKEN_BITS-1:0]    gthr_q [NUM_CHANNELS];
    logic signed [TOKEN_BITS-1:0]    bthr_q [NUM_CHANNELS];
    logic        [DURATION_BITS-1:0] dur_q  [NUM_CHANNELS];
    logic        [DURATION_BITS-1:0] rem_q  [NUM_CHANNELS];
    logic signed [TOKEN_BITS-1:0]    wr_tok;
    logic        [DURATION_BITS-1:0] wr_dur;

    assign wr_tok = data_in[TOKEN_BITS-1:0];
    assign wr_dur = data_in[DURATION_BITS-1:0];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic signed [NEW_TOKEN_BITS-1:0] gd, bd;
        logic                             sel, pass;
        logic signed [TOKEN_BITS-1:0]     good_n, bad_n, gthr_n, bthr_n;
        logic        [DURATION_BITS-1:0]  dur_n, rem_n;
        logic                             start_n, stop_n, start_q, stop_q, valid_q;
        state_t                           state_q, state_n;
`ifdef TTT_REFRACTORY_EN
        logic [RB-1:0]                    refr_q, refr_n;
`endif

        assign gd   = good_tokens_in[i*NEW_TOKEN_BITS +: NEW_TOKEN_BITS];
        assign bd   = bad_tokens_in[i*NEW_TOKEN_BITS +: NEW_TOKEN_BITS];
        assign sel  = broadcast || (channel_addr == ADDR_BITS'(i));
        assign pass = (good_q[i] >= gthr_q[i]) && (bad_q[i] <= bthr_q[i]);

        // Next-state decode for one channel; pulses default low every cycle.
        always_comb begin
            good_n  = good_q[i];
            bad_n   = bad_q[i];
            gthr_n  = gthr_q[i];
            bthr_n  = bthr_q[i];
            dur_n   = dur_q[i];
            rem_n   = rem_q[i];
            state_n = state_q;
            start_n = 1'b0;
            stop_n  = 1'b0;
`ifdef TTT_REFRACTORY_EN
            refr_n  = refr_q;
`endif
            if (enable) begin
                case (instruction)
                    OP_ADD_GOOD: good_n = sat_add(good_q[i], gd);
                    OP_ADD_BAD:  bad_n  = sat_add(bad_q[i], bd);
                    OP_SET_GOOD: if (sel) good_n = wr_tok;
                    OP_SET_BAD:  if (sel) bad_n  = wr_tok;
                    OP_SET_GTH:  if (sel) gthr_n = wr_tok;
                    OP_SET_BTH:  if (sel) bthr_n = wr_tok;
                    OP_SET_DUR:  if (sel) dur_n  = wr_dur;
                    OP_SET_REM: if (sel) begin
                        rem_n   = wr_dur;
                        state_n = (wr_dur != '0) ? ST_ON : ST_OFF;
`ifdef TTT_REFRACTORY_EN
                        refr_n  = '0;
`endif
                    end
                    OP_TALLY: begin
                        if (state_q == ST_OFF && pass) begin
                            state_n = ST_ON;
                            rem_n   = dur_q[i];
                            start_n = 1'b1;
                        end else if (state_q == ST_ON && rem_q[i] == '0 && pass) begin
                            rem_n = dur_q[i];
                        end else if (state_q == ST_ON && (bad_q[i] > bthr_q[i] || rem_q[i] == '0)) begin
                            rem_n  = '0;
                            stop_n = 1'b1;
`ifdef TTT_REFRACTORY_EN
                            state_n = ST_REFR;
                            refr_n  = RB'(REFRACTORY_STEPS);
`else
                            state_n = ST_OFF;
`endif
                        end
                    end
                    OP_COUNT: begin
                        if (state_q == ST_ON && rem_q[i] != '0) rem_n = rem_q[i] - 1'b1;
`ifdef TTT_REFRACTORY_EN
                        if (state_q == ST_REFR) begin
                            if (refr_q <= RB'(1)) begin
                                state_n = ST_OFF;
                                refr_n  = '0;
                            end else begin
                                refr_n = refr_q - 1'b1;
                            end
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end

        // Channel state register; reset overrides any instruction.
        always_ff @(posedge clock) begin
            if (reset) begin
                good_q[i] <= '0;
                bad_q[i]  <= '0;
                gthr_q[i] <= TOK_MAX;
                bthr_q[i] <= '0;
                dur_q[i]  <= '0;
                rem_q[i]  <= '0;
                state_q   <= ST_OFF;
                start_q   <= 1'b0;
                stop_q    <= 1'b0;
                valid_q   <= 1'b0;
`ifdef TTT_REFRACTORY_EN
                refr_q    <= '0;
`endif
            end else begin
                good_q[i] <= good_n;
                bad_q[i]  <= bad_n;
                gthr_q[i] <= gthr_n;
                bthr_q[i] <= bthr_n;
                dur_q[i]  <= dur_n;
                rem_q[i]  <= rem_n;
                state_q   <= state_n;
                start_q   <= start_n;
                stop_q    <= stop_n;
                valid_q   <= (state_n == ST_ON);
`ifdef TTT_REFRACTORY_EN
                refr_q    <= refr_n;
`endif
            end
        end

        assign token_start[i] = start_q;
        assign token_stop[i]  = stop_q;
        assign token_valid[i] = valid_q;
    end

    logic [DATA_BITS-1:0] data_n;
    logic                 hit;
    logic signed [TOKEN_BITS-1:0] rd_good, rd_bad, rd_gthr, rd_bthr;
    logic [DURATION_BITS-1:0]     rd_dur, rd_rem;

    // Readback / write-echo value; out-of-range address yields 0.
    always_comb begin
        data_n  = data_out;
        hit     = 1'b0;
        rd_good = '0;
        rd_bad  = '0;
        rd_gthr = '0;
        rd_bthr = '0;
        rd_dur  = '0;
        rd_rem  = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (channel_addr == ADDR_BITS'(i)) begin
                hit     = 1'b1;
                rd_good = good_q[i];
                rd_bad  = bad_q[i];
                rd_gthr = gthr_q[i];
                rd_bthr = bthr_q[i];
                rd_dur  = dur_q[i];
                rd_rem  = rem_q[i];
            end
        end
        if (enable) begin
            case (instruction)
                OP_SET_GOOD, OP_SET_BAD, OP_SET_GTH, OP_SET_BTH:
                    data_n = (broadcast || hit) ? DATA_BITS'(wr_tok) : '0;
                OP_SET_DUR, OP_SET_REM:
                    data_n = (broadcast || hit) ? DATA_BITS'(wr_dur) : '0;
                OP_GET_GOOD: data_n = hit ? DATA_BITS'(rd_good) : '0;
                OP_GET_BAD:  data_n = hit ? DATA_BITS'(rd_bad)  : '0;
                OP_GET_GTH:  data_n = hit ? DATA_BITS'(rd_gthr) : '0;
                OP_GET_BTH:  data_n = hit ? DATA_BITS'(rd_bthr) : '0;
                OP_GET_DUR:  data_n = hit ? DATA_BITS'(rd_dur)  : '0;
                OP_GET_REM:  data_n = hit ? DATA_BITS'(rd_rem)  : '0;
                default: ;
            endcase
        end
    end

    // Registered programming-bus readback.
    always_ff @(posedge clock) begin
        if (reset) data_out <= '0;
        else       data_out <= data_n;
    end
endmodule

// File: tb/tb_ttt_processor_array.sv
// tb/tb_ttt_processor_array.sv - table-driven self-checking bench for ttt_processor_array
module tb_ttt_processor_array;
    localparam int NC = 4, NB = 4, TB = 8, DRB = 8, DB = 8, AB = 3;
    localparam logic [3:0] ADDG = 4'b0000, ADDB = 4'b0001, SG = 4'b0010, GG = 4'b0011,
                           SB = 4'b0100, GB = 4'b0101, SR = 4'b0110, GR = 4'b0111,
                           TAL = 4'b1000, CD = 4'b1001, SGT = 4'b1010, GGT = 4'b1011,
                           SBT = 4'b1100, SD = 4'b1110, GD = 4'b1111;

    logic              clock = 1'b0;
    logic              reset, enable, broadcast;
    logic [3:0]        instruction;
    logic [AB-1:0]     channel_addr;
    logic [NC*NB-1:0]  good_tokens_in, bad_tokens_in;
    logic [NC-1:0]     token_start, token_stop, token_valid;
    logic [DB-1:0]     data_in, data_out;
    int                n_tests = 0;
    int                n_fail = 0;

    typedef struct {
        logic          rst;
        logic          en;
        logic [3:0]    op;
        logic [AB-1:0] addr;
        logic          bc;
        logic [DB-1:0] data;
        logic [15:0]   gt;
        logic [15:0]   bt;
        logic          chk;
        logic [DB-1:0] exp_d;
        logic [NC-1:0] exp_s;
        logic [NC-1:0] exp_p;
        logic [NC-1:0] exp_v;
    } vec_t;

    vec_t          vecs[$];
    logic [DB-1:0] sb_q[$];

    ttt_processor_array #(
        .NUM_CHANNELS(NC), .NEW_TOKEN_BITS(NB), .TOKEN_BITS(TB), .DURATION_BITS(DRB),
        .DATA_BITS(DB), .ADDR_BITS(AB), .REFRACTORY_STEPS(2)
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .instruction(instruction),
        .channel_addr(channel_addr), .broadcast(broadcast),
        .good_tokens_in(good_tokens_in), .bad_tokens_in(bad_tokens_in),
        .token_start(token_start), .token_stop(token_stop), .token_valid(token_valid),
        .data_in(data_in), .data_out(data_out)
    );

    always #5 clock = ~clock;

    function automatic void add(input logic rst, input logic en, input logic [3:0] op,
                                input logic [AB-1:0] addr, input logic bc, input logic [DB-1:0] data,
                                input logic [15:0] gt, input logic [15:0] bt, input logic chk,
                                input logic [DB-1:0] exp_d, input logic [NC-1:0] exp_s,
                                input logic [NC-1:0] exp_p, input logic [NC-1:0] exp_v);
        vec_t v;
        v.rst = rst; v.en = en; v.op = op; v.addr = addr; v.bc = bc; v.data = data;
        v.gt = gt; v.bt = bt; v.chk = chk; v.exp_d = exp_d;
        v.exp_s = exp_s; v.exp_p = exp_p; v.exp_v = exp_v;
        vecs.push_back(v);
    endfunction

    task automatic check(input int idx, input string what, input logic [7:0] got, input logic [7:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %h expected %h", idx, what, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [DB-1:0] e;
        reset = v.rst; enable = v.en; instruction = v.op; channel_addr = v.addr;
        broadcast = v.bc; data_in = v.data; good_tokens_in = v.gt; bad_tokens_in = v.bt;
        if (v.chk) sb_q.push_back(v.exp_d);
        @(posedge clock);
        #1;
        check(idx, "token_start", 8'(token_start), 8'(v.exp_s));
        check(idx, "token_stop",  8'(token_stop),  8'(v.exp_p));
        check(idx, "token_valid", 8'(token_valid), 8'(v.exp_v));
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check(idx, "data_out", data_out, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; instruction = '0; channel_addr = '0; broadcast = 1'b0;
        data_in = '0; good_tokens_in = '0; bad_tokens_in = '0;

        // saturation and sign handling
        add(0,1,SG,  0,1,8'd126,16'h0000,16'h0000,1,8'h7E,4'b0000,4'b0000,4'b0000);
        add(0,1,ADDG,0,0,8'd0,  16'h0083,16'h0000,1,8'h7E,4'b0000,4'b0000,4'b0000);
        add(0,1,GG,  0,0,8'd0,  16'h0000,16'h0000,1,8'h7F,4'b0000,4'b0000,4'b0000);
        add(0,1,GG,  1,0,8'd0,  16'h0000,16'h0000,1,8'h76,4'b0000,4'b0000,4'b0000);
        add(0,1,SB,  0,0,8'h83, 16'h0000,16'h0000,1,8'h83,4'b0000,4'b0000,4'b0000);
        add(0,1,ADDB,0,0,8'd0,  16'h0000,16'h0008,1,8'h83,4'b0000,4'b0000,4'b0000);
        add(0,1,GB,  0,0,8'd0,  16'h0000,16'h0000,1,8'h80,4'b0000,4'b0000,4'b0000);
        add(0,1,GB,  1,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,SB,  0,1,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,SG,  0,1,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        // ch2 start, countdown, stop
        add(0,1,SGT, 2,0,8'd4,  16'h0000,16'h0000,1,8'h04,4'b0000,4'b0000,4'b0000);
        add(0,1,SBT, 2,0,8'd1,  16'h0000,16'h0000,1,8'h01,4'b0000,4'b0000,4'b0000);
        add(0,1,SD,  2,0,8'd2,  16'h0000,16'h0000,1,8'h02,4'b0000,4'b0000,4'b0000);
        add(0,1,SG,  2,0,8'd5,  16'h0000,16'h0000,1,8'h05,4'b0000,4'b0000,4'b0000);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,1,8'h05,4'b0100,4'b0000,4'b0100);
        add(0,1,CD,  0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0100);
        add(0,1,CD,  0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0100);
        add(0,1,SG,  2,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0100);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0100,4'b0000);
        add(0,0,SG,  2,0,8'd99, 16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,GG,  2,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        // ch0 restart with remaining 0 and pass true
        add(0,1,SGT, 0,0,8'd1,  16'h0000,16'h0000,1,8'h01,4'b0000,4'b0000,4'b0000);
        add(0,1,SD,  0,0,8'd3,  16'h0000,16'h0000,1,8'h03,4'b0000,4'b0000,4'b0000);
        add(0,1,SG,  0,0,8'd2,  16'h0000,16'h0000,1,8'h02,4'b0000,4'b0000,4'b0000);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0001,4'b0000,4'b0001);
        for (int k = 0; k < 3; k++)
            add(0,1,CD,0,0,8'd0,16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,GR,  0,0,8'd0,  16'h0000,16'h0000,1,8'h03,4'b0000,4'b0000,4'b0001);
        // ch1 bad-token kill
        add(0,1,SR,  1,0,8'd5,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0011);
        add(0,1,SB,  1,0,8'd3,  16'h0000,16'h0000,1,8'h03,4'b0000,4'b0000,4'b0011);
        add(0,1,SBT, 1,0,8'd1,  16'h0000,16'h0000,1,8'h01,4'b0000,4'b0000,4'b0011);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0010,4'b0001);
        add(0,1,GR,  1,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0001);
        // addressing
        add(0,1,SD,  1,0,8'd9,  16'h0000,16'h0000,1,8'h09,4'b0000,4'b0000,4'b0001);
        add(0,1,GD,  1,0,8'd0,  16'h0000,16'h0000,1,8'h09,4'b0000,4'b0000,4'b0001);
        add(0,1,GD,  0,0,8'd0,  16'h0000,16'h0000,1,8'h03,4'b0000,4'b0000,4'b0001);
        add(0,1,GD,  3,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,SD,  5,0,8'd7,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,GD,  1,0,8'd0,  16'h0000,16'h0000,1,8'h09,4'b0000,4'b0000,4'b0001);
        add(0,1,GD,  5,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,GD,  3,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,GGT, 2,1,8'd0,  16'h0000,16'h0000,1,8'h04,4'b0000,4'b0000,4'b0001);
        add(0,1,SR,  0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0000);
        // reset together with a TALLY that would otherwise start ch0
        add(0,1,SR,  3,0,8'd4,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b1000);
        add(1,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,GGT, 0,0,8'd0,  16'h0000,16'h0000,1,8'h7F,4'b0000,4'b0000,4'b0000);
        add(0,1,GD,  0,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
        // stop followed by re-arm (refractory-dependent tail)
        add(0,1,SGT, 0,0,8'd1,  16'h0000,16'h0000,1,8'h01,4'b0000,4'b0000,4'b0000);
        add(0,1,SG,  0,0,8'd2,  16'h0000,16'h0000,1,8'h02,4'b0000,4'b0000,4'b0000);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0001,4'b0000,4'b0001);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0001);
        add(0,1,SB,  0,0,8'd1,  16'h0000,16'h0000,1,8'h01,4'b0000,4'b0000,4'b0001);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0001,4'b0000);
        add(0,1,SB,  0,0,8'd0,  16'h0000,16'h0000,1,8'h00,4'b0000,4'b0000,4'b0000);
`ifdef TTT_REFRACTORY_EN
        add(0,1,CD,  0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,CD,  0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0000,4'b0000,4'b0000);
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0001,4'b0000,4'b0001);
`else
        add(0,1,TAL, 0,0,8'd0,  16'h0000,16'h0000,0,8'h00,4'b0001,4'b0000,4'b0001);
`endif

        repeat (2) @(posedge clock);
        #1;
        check(-1, "reset data_out",    data_out, 8'h00);
        check(-1, "reset token_start", 8'(token_start), 8'h00);
        check(-1, "reset token_stop",  8'(token_stop),  8'h00);
        check(-1, "reset token_valid", 8'(token_valid), 8'h00);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ttt_processor_array.md
Name: ttt_processor_array

Overview:
- NUM_CHANNELS independent token-threshold-timer channels behind one shared instruction and programming bus.
- Channel state: good/bad token counters, thresholds, duration, countdown.
- Differences from a single-channel processor: per-channel addressing with broadcast, saturating token arithmetic, three-state channel FSM, registered token_valid level.
- Sits between the token router (parallel token deltas) and the event encoder (start/stop pulses).

Parameters:
- NUM_CHANNELS, 4, number of channels.
- NEW_TOKEN_BITS, 4, width of each signed per-channel token delta.
- TOKEN_BITS, 8, signed width of token counters and thresholds.
- DURATION_BITS, 8, unsigned width of duration and countdown.
- DATA_BITS, 8, programming bus width; must be >= max(TOKEN_BITS, DURATION_BITS).
- ADDR_BITS, 2, channel address width; must be >= clog2(NUM_CHANNELS).
- REFRACTORY_STEPS, 2, countdown steps spent refractory (used only with REFRACTORY_EN).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  instruction executes only when high.
- instruction  in  4  opcode, decoded only when enable=1.
- channel_addr  in  ADDR_BITS  target channel for SET/GET.
- broadcast  in  1  SET writes every channel; ignored by GET.
- good_tokens_in  in  NUM_CHANNELS*NEW_TOKEN_BITS  signed deltas; channel i is slice i.
- bad_tokens_in  in  NUM_CHANNELS*NEW_TOKEN_BITS  signed deltas; channel i is slice i.
- token_start  out  NUM_CHANNELS  one-cycle pulse per channel.
- token_stop  out  NUM_CHANNELS  one-cycle pulse per channel.
- token_valid  out  NUM_CHANNELS  high while the channel is ON.
- data_in  in  DATA_BITS  programming data.
- data_out  out  DATA_BITS  registered readback.

Behaviour:
- Reset values:
  - Counters, remaining, outputs and data_out all 0.
  - Channel state OFF.
  - Good threshold = 2^(TOKEN_BITS-1)-1.
  - Bad threshold = 0.
  - Duration = 0.
- All outputs are registered; every effect is visible one clock after the instruction.
- token_start/token_stop are 0 on every cycle unless set by that cycle's TALLY, including enable=0 cycles. A pulse therefore never lasts more than one clock.
- token_valid = (state == ON).
- Opcodes 0000 ADD_GOOD / 0001 ADD_BAD, all channels:
  - counter <= sat(counter + sext(delta)).
  - sat clamps to [-2^(TOKEN_BITS-1), 2^(TOKEN_BITS-1)-1]; no wrap.
  - data_out held.
- SET opcodes, data taken from low bits of data_in:
  - 0010 good count, 0100 bad count, 1010 good threshold, 1100 bad threshold, 1110 duration.
  - Written to the addressed channel, or to all channels when broadcast=1.
  - data_out <= written value.
- 0110 SET_REMAIN: remaining <= data_in. State becomes ON if nonzero, OFF if zero; this overrides REFRACTORY. No pulses.
- GET opcodes, read the addressed channel:
  - 0011 good, 0101 bad, 0111 remaining, 1011 good threshold, 1101 bad threshold, 1111 duration.
  - Token values are sign-extended to DATA_BITS; duration values are zero-extended.
- Out-of-range channel_addr (>= NUM_CHANNELS): SET with broadcast=0 is ignored and data_out <= 0; GET returns 0.
- 1000 TALLY, all channels in parallel. pass = good >= gthr AND bad <= bthr (signed compare).
  - OFF and pass: -> ON, remaining <= duration, start=1.
  - ON, remaining==0 and pass: stay ON, remaining <= duration, no pulse.
  - ON and (bad > bthr OR remaining==0): -> OFF (or REFRACTORY), remaining <= 0, stop=1.
  - Otherwise: no change.
  - Duration 0 on turn-on: the channel is ON with remaining 0 and re-evaluates at the next TALLY.
- 1001 COUNTDOWN, all channels: ON and remaining != 0 -> remaining - 1. Never underflows.
- enable=0: all state held except the pulse clear.
- Reset mid-operation wins over any instruction in the same cycle.

Optional Feature:
- Macro: TTT_REFRACTORY_EN.
- Defined:
  - A channel that stops enters REFRACTORY, with a refractory counter <= REFRACTORY_STEPS.
  - COUNTDOWN decrements the counter; when it reaches 0 the channel goes to OFF.
  - TALLY never starts a channel in REFRACTORY.
  - token_valid=0 in REFRACTORY.
  - REFRACTORY_STEPS=0 means the next COUNTDOWN returns the channel to OFF.
- Undefined: no REFRACTORY state exists; a stop goes directly to OFF.

Test Plan:
- Saturation: reset; SET_GOOD broadcast 126; ADD_GOOD with ch0 delta +3 and ch1 delta -8 -> GET ch0 = 127, GET ch1 = 118.
- Start/stop: ch2 gthr=4, bthr=1, duration=2, good=5; TALLY -> token_start=0100 for 1 cycle, token_valid[2]=1.
  - Then COUNTDOWN x2, TALLY with good=0 -> token_stop[2]=1, valid[2]=0.
- Restart without pulse: ch0 ON with remaining 0 and pass true; TALLY -> no start/stop, GET remaining = duration.
- Bad-token kill: ch1 ON with remaining 5; SET_BAD ch1=3, bthr=1; TALLY -> stop[1]=1, GET remaining = 0.
- Addressing: SET_DURATION addr=1, broadcast=0, data 9 -> only ch1 reads 9.
  - SET with addr=5 at NUM_CHANNELS=4 -> no channel changes, data_out = 0.
  - Reset asserted together with TALLY -> all outputs 0.
- TTT_REFRACTORY_EN with REFRACTORY_STEPS=2: a stopped channel with pass true gets no start after 1 COUNTDOWN + TALLY; after 2 COUNTDOWNs + TALLY -> start=1.
